// File: rtl/estufa_pkg.sv
// estufa_pkg: shared FSM states, sensor indices and widths for the greenhouse grading sequencer
package estufa_pkg;
  typedef enum logic [2:0] {OCIOSO, SELECIONA, CAPTURA, CALCULA, PUBLICA} estado_t;
  localparam logic [1:0] SENS_TEMPERATURA = 2'd0;
  localparam logic [1:0] SENS_UMIDADE = 2'd1;
  localparam logic [1:0] SENS_LUMINOSIDADE = 2'd2;
  localparam logic [1:0] SENS_PH = 2'd3;
  localparam int NOTA_W = 4;
  localparam int SOMA_W = 6;
endpackage

// File: rtl/sequenciador_avaliacao_if.sv
// sequenciador_avaliacao_if: control, shared-grader and published-grade signals of the sequencer
interface sequenciador_avaliacao_if;
  import estufa_pkg::*;
  logic enable;
  logic inicia;
  logic [NOTA_W-1:0] nota_in;
  logic [1:0] sel;
  logic avalia;
  logic [NOTA_W-1:0] nota_temperatura;
  logic [NOTA_W-1:0] nota_umidade;
  logic [NOTA_W-1:0] nota_luminosidade;
  logic [NOTA_W-1:0] nota_pH;
  logic [NOTA_W-1:0] media;
  logic pronto;
  logic ocupado;
  modport master (
    output enable, inicia, nota_in,
    input sel, avalia, nota_temperatura, nota_umidade, nota_luminosidade, nota_pH, media, pronto, ocupado
  );
  modport slave (
    input enable, inicia, nota_in,
    output sel, avalia, nota_temperatura, nota_umidade, nota_luminosidade, nota_pH, media, pronto, ocupado
  );
endinterface

// File: rtl/acumulador_notas.sv
// acumulador_notas: four scratch grade slots, published copies and their floor average
module acumulador_notas
  import estufa_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic we,
  input  logic pub,
  input  logic [1:0] idx,
  input  logic [NOTA_W-1:0] nota_in,
  output logic [3:0][NOTA_W-1:0] notas,
  output logic [NOTA_W-1:0] media
);
  logic [3:0][NOTA_W-1:0] slot_q, slot_d, notas_q, notas_d;
  logic [NOTA_W-1:0] media_q, media_d;
  logic [SOMA_W-1:0] soma;
  assign soma = SOMA_W'(slot_q[0]) + SOMA_W'(slot_q[1]) + SOMA_W'(slot_q[2]) + SOMA_W'(slot_q[3]);
  always_comb begin
    slot_d = clr ? '0 : slot_q;
    if (we && !clr) slot_d[idx] = nota_in;
    notas_d = pub ? slot_q : notas_q;
    media_d = pub ? NOTA_W'(soma >> 2) : media_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= '0;
      notas_q <= '0;
      media_q <= '0;
    end else begin
      slot_q <= slot_d;
      notas_q <= notas_d;
      media_q <= media_d;
    end
  end
  assign notas = notas_q;
  assign media = media_q;
endmodule

// File: rtl/sequenciador_avaliacao.sv
// sequenciador_avaliacao: time-multiplexes one grader over four sensors and publishes grades plus average
module sequenciador_avaliacao
  import estufa_pkg::*;
#(
  parameter int LAT_NOTA = 1,
  parameter int PERIODO = 0
) (
  input logic clock,
  input logic reset,
  sequenciador_avaliacao_if.slave bus
);
  estado_t est_q, est_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] esp_q, esp_d;
  logic [15:0] per_q, per_d;
  logic disparo;
  logic [3:0][NOTA_W-1:0] notas;
  assign disparo = bus.inicia || (PERIODO > 0 && per_q == 16'(PERIODO - 1));
  always_comb begin
    est_d = est_q;
    sel_d = sel_q;
    esp_d = esp_q;
    per_d = per_q;
    if (!bus.enable) begin
      est_d = OCIOSO;
      sel_d = SENS_TEMPERATURA;
    end else begin
      case (est_q)
        OCIOSO: begin
          est_d = disparo ? SELECIONA : OCIOSO;
          sel_d = SENS_TEMPERATURA;
          esp_d = '0;
          per_d = disparo ? '0 : per_q + 16'd1;
        end
        SELECIONA: begin
          est_d = esp_q == 3'(LAT_NOTA - 1) ? CAPTURA : SELECIONA;
          esp_d = esp_q + 3'd1;
        end
        CAPTURA: begin
          est_d = sel_q == SENS_PH ? CALCULA : SELECIONA;
          sel_d = sel_q == SENS_PH ? sel_q : sel_q + 2'd1;
          esp_d = '0;
        end
        CALCULA: est_d = PUBLICA;
        default: begin
          est_d = OCIOSO;
          sel_d = SENS_TEMPERATURA;
        end
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      est_q <= OCIOSO;
      sel_q <= '0;
      esp_q <= '0;
      per_q <= '0;
    end else begin
      est_q <= est_d;
      sel_q <= sel_d;
      esp_q <= esp_d;
      per_q <= per_d;
    end
  end
  assign bus.sel = sel_q;
  assign bus.avalia = est_q == SELECIONA || est_q == CAPTURA;
  assign bus.pronto = est_q == PUBLICA;
  assign bus.ocupado = est_q != OCIOSO;
  // dropping enable discards the partial run, so scratch clears and nothing publishes
  acumulador_notas u_acum (
    .clock(clock),
    .reset(reset),
    .clr(!bus.enable),
    .we(est_q == CAPTURA),
    .pub(est_q == CALCULA && bus.enable),
    .idx(sel_q),
    .nota_in(bus.nota_in),
    .notas(notas),
    .media(bus.media)
  );
  assign bus.nota_temperatura = notas[SENS_TEMPERATURA];
  assign bus.nota_umidade = notas[SENS_UMIDADE];
  assign bus.nota_luminosidade = notas[SENS_LUMINOSIDADE];
  assign bus.nota_pH = notas[SENS_PH];
endmodule

// File: doc/sequenciador_avaliacao.md
Name: sequenciador_avaliacao

Overview:
Time-multiplexes one shared grading unit (atribuidor_nota) across the four greenhouse sensors: temperatura, umidade, luminosidade and pH.
- Selects each sensor in turn, waits out the grader latency and captures the returned grade.
- Computes the floor average of the four grades and publishes all five values together as one coherent set.
- Replaces the four parallel grader instances and the contador/registrador/unidade_controle trio in the estufa top level.

Parameters:
- LAT_NOTA, 1, clock cycles from a stable sel/avalia to a valid nota_in (1..7).
- PERIODO, 0, automatic re-evaluation interval in cycles while idle; 0 disables periodic mode (inicia only).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  1  global enable; low aborts any run and freezes the period counter.
- inicia  input  1  single-cycle start request; honoured only in OCIOSO with enable=1.
- nota_in  input  4  grade returned by the shared grader for the currently selected sensor.
- sel  output  2  sensor index driven to the grader mux: 0 temperatura, 1 umidade, 2 luminosidade, 3 pH.
- avalia  output  1  grader enable; high in SELECIONA and CAPTURA only.
- nota_temperatura, nota_umidade, nota_luminosidade, nota_pH  output  4 each  published grades.
- media  output  4  published average.
- pronto  output  1  one-cycle pulse when a new set is published.
- ocupado  output  1  high in every state except OCIOSO.

Behaviour:
- Reset (synchronous, active-high): state OCIOSO, and every output cleared to 0 (sel, avalia, all notas, media, pronto, ocupado). Period counter and scratch registers are also cleared.
- States and transitions:
  - OCIOSO: go to SELECIONA with sel=0 when enable=1 and a trigger occurs.
  - Trigger = inicia=1, or (PERIODO>0 and period counter == PERIODO-1).
  - SELECIONA: hold sel, avalia=1, for exactly LAT_NOTA cycles (wait counter), then go to CAPTURA.
  - CAPTURA: one cycle, sel held, avalia=1. At its closing edge, nota_in is stored into scratch slot [sel].
    - If sel<3: sel+1 and back to SELECIONA.
    - If sel=3: go to CALCULA.
  - CALCULA: one cycle. At its closing edge:
    - the four scratch grades copy into the nota_* outputs;
    - media <= (sum of the four) >> 2, with sum held at 6 bits (max 60, no overflow).
  - PUBLICA: one cycle, pronto=1, then return to OCIOSO.
- Latency: trigger accepted at cycle T means pronto is high at cycle T+4*(LAT_NOTA+1)+2. With LAT_NOTA=1, pronto is high at T+10, and the outputs are already updated in that cycle.
- Outputs hold their last published values until the next CALCULA. Scratch values never reach the outputs mid-run.
- Period counter:
  - counts only in OCIOSO with enable=1;
  - clears on any accepted trigger;
  - holds its value when enable=0.
- Simultaneous inicia and period timeout: exactly one run.
- inicia while ocupado=1: ignored, not queued.
- enable falling mid-run (any state other than OCIOSO): next state OCIOSO, and
  - avalia=0, sel=0, no pronto;
  - published outputs unchanged; scratch values discarded.
- reset mid-run: same as power-on reset. Published outputs clear to 0.
- nota_in is only sampled in CAPTURA; its value in every other state is don't-care.

Decomposition:
- Shared package estufa_pkg holds:
  - state encoding constants (OCIOSO, SELECIONA, CAPTURA, CALCULA, PUBLICA);
  - sensor index constants (SENS_TEMPERATURA=0, SENS_UMIDADE=1, SENS_LUMINOSIDADE=2, SENS_PH=3);
  - widths: NOTA_W=4, SOMA_W=6.
- One sub-module, acumulador_notas, holds the four scratch slots, the slot write by index, and the sum/shift.
- The FSM, wait counter and period counter stay in sequenciador_avaliacao.

Test Plan:
- Basic run: reset, then inicia at cycle T with grader model returning 8,6,4,2 for sel 0..3 (LAT_NOTA=1) -> pronto only at T+10; outputs 8,6,4,2; media=5; sel sequence 0,0,1,1,2,2,3,3.
- Rounding and max: grades 15,15,15,14 -> media=14. Grades 15,15,15,15 -> media=15. Grades 0,0,0,3 -> media=0.
- Abort: enable=0 at T+5 -> ocupado falls next cycle; no pronto; published outputs keep the prior set; a fresh inicia afterwards runs a full 10-cycle sequence.
- Periodic, PERIODO=16, no inicia: after reset, pronto pulses repeat at fixed spacing of 16+10 cycles. inicia asserted during a run -> no extra pronto.
- LAT_NOTA=3: grader model valid only 3 cycles after sel changes -> grades captured correctly, pronto at T+18.
- Reset asserted at T+7 mid-run -> all outputs 0 on the next cycle; state OCIOSO; no pronto afterwards.
